// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper: state encoding,
// settle-counter width and table-width helper.
package tt_pkg;

  localparam int unsigned SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    FIN    = 2'd3
  } tt_state_e;

  function automatic int unsigned tt_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Sweep request/status bus between the sweeper (master) and the circuit side.
// Optional TRUTH_TABLE_CHECK_EN adds the expected-table compare signals.
interface truth_table_sweeper_if #(
  parameter int unsigned N_IN = 2
);
  import tt_pkg::*;

  localparam int unsigned TW = tt_width(N_IN);

  logic            start;
  logic [N_IN-1:0] vec_out;
  logic            f_in;
  logic            busy;
  logic            done;
  logic [TW-1:0]   table_out;
`ifdef TRUTH_TABLE_CHECK_EN
  logic [TW-1:0]   expected;
  logic            mismatch;

  modport master (input start, f_in, expected,
                  output vec_out, busy, done, table_out, mismatch);
  modport slave  (output start, f_in, expected,
                  input vec_out, busy, done, table_out, mismatch);
`else
  modport master (input start, f_in,
                  output vec_out, busy, done, table_out);
  modport slave  (output start, f_in,
                  input vec_out, busy, done, table_out);
`endif

endinterface

// File: rtl/truth_table_sweeper_settle_counter.sv
// Settle-time counter: counts WAIT cycles and flags the last one, wrapping to 0.
module tt_settle_counter
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired_c
);

  localparam logic [SETTLE_W-1:0] LAST = (SETTLE == 0) ? '0 : SETTLE_W'(SETTLE - 1);

  logic [SETTLE_W-1:0] r_count;

  assign o_expired_c = (r_count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_expired_c ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all N_IN-bit input vectors, samples f_in after SETTLE cycles each and
// assembles the truth table. Optional TRUTH_TABLE_CHECK_EN adds a mismatch flag.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1
) (
  input logic                   clk,
  input logic                   rst,
  truth_table_sweeper_if.master bus
);

  localparam int unsigned     TW       = tt_width(N_IN);
  localparam logic [N_IN-1:0] VEC_LAST = N_IN'(TW - 1);

  tt_state_e       r_state;
  tt_state_e       w_state_nxt;
  logic [N_IN-1:0] r_vec;
  logic [TW-1:0]   r_table;
  logic [TW-1:0]   w_table_upd;
  logic            r_busy;
  logic            r_done;
  logic            w_accept;
  logic            w_last;
  logic            w_cnt_clr;
  logic            w_cnt_en;
  logic            w_expired;

  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_last   = (r_vec == VEC_LAST);

  tt_settle_counter #(.SETTLE(SETTLE)) u_settle (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_cnt_clr),
    .i_en        (w_cnt_en),
    .o_expired_c (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = (SETTLE > 0) ? WAIT : SAMPLE;
          w_cnt_clr   = 1'b1;
        end
      end
      WAIT: begin
        w_cnt_en = 1'b1;
        if (w_expired) w_state_nxt = SAMPLE;
      end
      SAMPLE:  w_state_nxt = w_last ? FIN : ((SETTLE > 0) ? WAIT : SAMPLE);
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Table including the bit captured this cycle; also feeds the mismatch compare.
  always_comb begin
    w_table_upd        = r_table;
    w_table_upd[r_vec] = bus.f_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec   <= '0;
      r_table <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == WAIT) || (w_state_nxt == SAMPLE);
      r_done <= (w_state_nxt == FIN);
      if (w_accept) begin
        r_vec   <= '0;
        r_table <= '0;
      end else if (r_state == SAMPLE) begin
        r_table <= w_table_upd;
        if (!w_last) r_vec <= r_vec + 1'b1;
      end
    end
  end

  assign bus.vec_out   = r_vec;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.table_out = r_table;

`ifdef TRUTH_TABLE_CHECK_EN
  logic r_mismatch;

  // Evaluated on the final capture so the flag is valid during FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mismatch <= 1'b0;
    end else if (w_accept) begin
      r_mismatch <= 1'b0;
    end else if ((r_state == SAMPLE) && w_last) begin
      r_mismatch <= (w_table_upd != bus.expected);
    end
  end

  assign bus.mismatch = r_mismatch;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper (SETTLE=1 and SETTLE=0 instances) with
// a table scoreboard; also exercises mismatch when TRUTH_TABLE_CHECK_EN is defined.
module tb_truth_table_sweeper;
  import tt_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic sel;
  int   mode;
  logic [3:0] expv;

  int checks   = 0;
  int failures = 0;
  logic [3:0] sb_q[$];

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(2)) bo ();
  truth_table_sweeper_if #(.N_IN(2)) bz ();

  truth_table_sweeper #(.N_IN(2), .SETTLE(1)) u_one  (.clk(clk), .rst(rst), .bus(bo));
  truth_table_sweeper #(.N_IN(2), .SETTLE(0)) u_zero (.clk(clk), .rst(rst), .bus(bz));

  // Circuit under exercise: A = vec[1], B = vec[0]
  function automatic logic model(input int m, input logic [1:0] v);
    case (m)
      0:       return v[1] ^ v[0];
      1:       return v[1] & v[0];
      2:       return ~v[1];
      default: return v[1] | v[0];
    endcase
  endfunction

  assign bo.start = start & ~sel;
  assign bz.start = start & sel;
  assign bo.f_in  = model(mode, bo.vec_out);
  assign bz.f_in  = model(mode, bz.vec_out);

  logic       obs_busy, obs_done;
  logic [1:0] obs_vec;
  logic [3:0] obs_table;
  assign obs_busy  = sel ? bz.busy      : bo.busy;
  assign obs_done  = sel ? bz.done      : bo.done;
  assign obs_vec   = sel ? bz.vec_out   : bo.vec_out;
  assign obs_table = sel ? bz.table_out : bo.table_out;

`ifdef TRUTH_TABLE_CHECK_EN
  logic obs_mm;
  assign bo.expected = expv;
  assign bz.expected = expv;
  assign obs_mm = sel ? bz.mismatch : bo.mismatch;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One sweep on the selected DUT; poke re-asserts start while busy.
  task automatic run_sweep(input logic [3:0] exp_tbl, input int exp_busy,
                           input int settle, input bit poke);
    int busy_n = 0;
    int done_n = 0;
    int extra  = 0;
    bit vec_ok = 1'b1;
    logic exp_mm;
    exp_mm = (exp_tbl != expv);
    sb_q.push_back(exp_tbl);
    start = 1'b1;
    cyc();
    start = 1'b0;
`ifdef TRUTH_TABLE_CHECK_EN
    chk("mismatch_clr_on_start", 32'(obs_mm), 32'd0);
`endif
    for (int i = 0; i < 200 && done_n == 0; i++) begin
      if (obs_busy) begin
        if (obs_vec !== 2'(busy_n / (settle + 1))) vec_ok = 1'b0;
        busy_n++;
        if (poke && busy_n == 2) start = 1'b1;
        if (poke && busy_n == 3) start = 1'b0;
      end
      if (obs_done) begin
        done_n++;
        chk("table", 32'(obs_table), (sb_q.size() > 0) ? 32'(sb_q.pop_front()) : 32'hdead);
        chk("fin_busy_low", 32'(obs_busy), 32'd0);
        chk("fin_vec_hold", 32'(obs_vec), 32'd3);
`ifdef TRUTH_TABLE_CHECK_EN
        chk("mismatch_fin", 32'(obs_mm), 32'(exp_mm));
`endif
      end else begin
        cyc();
      end
    end
    chk("done_seen", 32'(done_n), 32'd1);
    chk("busy_cycles", 32'(busy_n), 32'(exp_busy));
    chk("vec_sequence", 32'(vec_ok), 32'd1);
    cyc();
    chk("done_one_cycle", 32'(obs_done), 32'd0);
    for (int i = 0; i < 12; i++) begin
      if (obs_done || obs_busy) extra++;
      cyc();
    end
    chk("no_extra_sweep", 32'(extra), 32'd0);
  endtask

  initial begin
    int done_n;
    int first_at;
    int last_at;
    bit gap_ok;

    rst   = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    mode  = 0;
    expv  = 4'b0000;
    repeat (3) cyc();
    chk("rst_busy", 32'({bo.busy, bz.busy}), 32'd0);
    chk("rst_done", 32'({bo.done, bz.done}), 32'd0);
    chk("rst_vec", 32'({bo.vec_out, bz.vec_out}), 32'd0);
    chk("rst_table", 32'({bo.table_out, bz.table_out}), 32'd0);
    rst = 1'b0;
    cyc();

    // Reset during the second WAIT abandons the sweep
    mode  = 2;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    chk("pre_rst_table", 32'(obs_table), 32'h1);
    chk("pre_rst_vec", 32'(obs_vec), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("midrst_busy", 32'(obs_busy), 32'd0);
    chk("midrst_vec", 32'(obs_vec), 32'd0);
    chk("midrst_table", 32'(obs_table), 32'd0);
    done_n = 0;
    for (int i = 0; i < 20; i++) begin
      if (obs_done || obs_busy) done_n++;
      cyc();
    end
    chk("midrst_no_done", 32'(done_n), 32'd0);

    // SETTLE=1 sweeps: XOR, AND, then NOT A (no stale bits)
    mode = 0; run_sweep(4'b0110, 8, 1, 1'b0);
    mode = 1; run_sweep(4'b1000, 8, 1, 1'b0);
    mode = 2; run_sweep(4'b0011, 8, 1, 1'b0);

    // Expected-table compare: match, mismatch, then cleared by next start
    mode = 0;
    expv = 4'b0110; run_sweep(4'b0110, 8, 1, 1'b0);
    expv = 4'b0111; run_sweep(4'b0110, 8, 1, 1'b0);
    expv = 4'b0110; run_sweep(4'b0110, 8, 1, 1'b0);

    // SETTLE=0, OR, with start re-asserted while busy
    sel  = 1'b1;
    mode = 3;
    run_sweep(4'b1110, 4, 0, 1'b1);

    // start held for 30 cycles: back-to-back sweeps every 10 cycles
    sel  = 1'b0;
    mode = 0;
    repeat (3) sb_q.push_back(4'b0110);
    done_n   = 0;
    first_at = -1;
    last_at  = -1;
    gap_ok   = 1'b1;
    start    = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (obs_done) begin
        done_n++;
        if (first_at < 0) first_at = i;
        else if (i - last_at != 10) gap_ok = 1'b0;
        last_at = i;
        chk("held_table", 32'(obs_table), (sb_q.size() > 0) ? 32'(sb_q.pop_front()) : 32'hdead);
      end
    end
    start = 1'b0;
    chk("held_done_count", 32'(done_n), 32'd3);
    chk("held_first_done", 32'(first_at), 32'd8);
    chk("held_done_gap", 32'(gap_ok), 32'd1);
    cyc();
    cyc();
    chk("held_idle_after", 32'(obs_busy), 32'd0);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
